// File: rtl/vec_out_pkg.sv
// ============================================================================
//  Module   : vec_out_pkg
//  Purpose  : Shared types and constants for the vector output serializer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vec_out_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    SEND   = 2'd2
  } state_t;

  localparam int SEQ_WIDTH = 8;

  // Guarded so a single-lane build still gets a 1-bit index.
  function automatic int laneIdxWidth(input int vectorSize);
    return (vectorSize > 1) ? $clog2(vectorSize) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vec_out_fifo.sv
// ============================================================================
//  Module   : vec_out_fifo
//  Purpose  : Vector-wide FIFO with same-edge push-through-pop when full.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_out_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wrPtr;
  logic [c_PTR_W-1:0] r_rdPtr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_doPush;
  logic               w_doPop;

  assign full     = (r_count == c_CNT_W'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign dout     = r_mem[r_rdPtr];
  assign w_doPop  = pop & ~empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_doPush = push & (~full | w_doPop);

  always_ff @(posedge clock) begin
    if (w_doPush) r_mem[r_wrPtr] <= din;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/vector_output_serializer.sv
// ============================================================================
//  Module   : vector_output_serializer
//  Purpose  : Buffers flagged CPU output vectors and streams them lane by lane
//             under valid/ready. VEC_OUT_HEADER_EN adds a sequence-number beat.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_output_serializer
  import vec_out_pkg::*;
#(
  parameter int VECTOR_SIZE  = 6,
  parameter int OUTPUT_WIDTH = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                outFlag,
  input  logic [VECTOR_SIZE*OUTPUT_WIDTH-1:0] out,
  output logic [OUTPUT_WIDTH-1:0]             byteData,
  output logic                                byteValid,
  input  logic                                byteReady,
  output logic [$clog2(FIFO_DEPTH):0]         fifoCount,
  output logic                                overflow,
  output logic                                busy
);

  localparam int c_VEC_W = VECTOR_SIZE * OUTPUT_WIDTH;
  localparam int c_IDX_W = laneIdxWidth(VECTOR_SIZE);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [c_IDX_W-1:0] c_LAST_LANE = c_IDX_W'(VECTOR_SIZE - 1);
`ifdef VEC_OUT_HEADER_EN
  localparam state_t c_FIRST = HEADER;
`else
  localparam state_t c_FIRST = SEND;
`endif

  state_t                  r_state;
  state_t                  w_nextState;
  logic [c_IDX_W-1:0]      r_laneIdx;
  logic                    r_overflow;
  logic [c_VEC_W-1:0]      w_head;
  logic [OUTPUT_WIDTH-1:0] w_lanes [VECTOR_SIZE];
  logic [c_CNT_W-1:0]      w_count;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_xfer;
  logic                    w_pop;
`ifdef VEC_OUT_HEADER_EN
  logic [SEQ_WIDTH-1:0]    r_seq;
`endif

  vec_out_fifo #(
    .WIDTH (c_VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (outFlag),
    .pop   (w_pop),
    .din   (out),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  for (genvar gi = 0; gi < VECTOR_SIZE; gi++) begin : g_lane
    assign w_lanes[gi] = w_head[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH];
  end

  assign byteValid = (r_state != IDLE);
  assign w_xfer    = byteValid & byteReady;
  assign w_pop     = w_xfer & (r_state == SEND) & (r_laneIdx == c_LAST_LANE);
  assign fifoCount = w_count;
  assign overflow  = r_overflow;
  assign busy      = (r_state != IDLE) | ~w_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_laneIdx  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_xfer && r_state == SEND) r_laneIdx <= w_pop ? '0 : r_laneIdx + 1'b1;
      if (outFlag && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

`ifdef VEC_OUT_HEADER_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_seq <= '0;
    else if (w_xfer && r_state == HEADER) r_seq <= r_seq + 1'b1;
  end
`endif

  // A same-edge push into a single-entry FIFO also counts as "another vector".
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_nextState = c_FIRST;
      HEADER:  if (byteReady) w_nextState = SEND;
      SEND:    if (w_pop) w_nextState = (w_count > c_CNT_W'(1) || outFlag) ? c_FIRST : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    byteData = '0;
    case (r_state)
`ifdef VEC_OUT_HEADER_EN
      HEADER:  byteData = OUTPUT_WIDTH'(r_seq);
`endif
      SEND:    byteData = w_lanes[r_laneIdx];
      default: byteData = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_output_serializer.sv
// ============================================================================
//  Module   : tb_vector_output_serializer
//  Purpose  : Self-checking bench for vector_output_serializer (queue model).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_output_serializer;

  localparam int VS    = 6;
  localparam int OW    = 8;
  localparam int DEPTH = 4;
`ifdef VEC_OUT_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int BEATS = VS + HDR;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          outFlag = 1'b0;
  logic          byteReady = 1'b0;
  logic [47:0]   outVec = '0;
  logic [7:0]    byteData;
  logic          byteValid;
  logic [2:0]    fifoCount;
  logic          overflow;
  logic          busy;

  always #5 clock = ~clock;

  vector_output_serializer #(
    .VECTOR_SIZE  (VS),
    .OUTPUT_WIDTH (OW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .outFlag   (outFlag),
    .out       (outVec),
    .byteData  (byteData),
    .byteValid (byteValid),
    .byteReady (byteReady),
    .fifoCount (fifoCount),
    .overflow  (overflow),
    .busy      (busy)
  );

  int nTests = 0;
  int nFail  = 0;

  // Reference model: queue of stored vectors, head vector's beat position.
  logic [47:0] q[$];
  bit          mValid;
  int          mIdx;
  bit          mOvf;
  int          mSeq;
  logic [7:0]  rxLog[$];

  typedef struct {
    logic [47:0] vec;
    logic [3:0]  readyPat;
    logic [47:0] expStream;  // beats in send order, first beat in the MSBs
  } vecRec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] expData();
    logic [47:0] h;
    if (!mValid) return 8'h00;
    if (HDR != 0 && mIdx == 0) return 8'(mSeq);
    h = q[0];
    return h[(mIdx - HDR)*8 +: 8];
  endfunction

  task automatic modelReset();
    q.delete();
    mValid = 0;
    mIdx   = 0;
    mOvf   = 0;
    mSeq   = 0;
  endtask

  task automatic modelEdge();
    int  sizeBefore;
    bit  xfer;
    bit  popNow;
    sizeBefore = q.size();
    xfer   = mValid && byteReady;
    popNow = xfer && (mIdx == BEATS - 1);
    if (popNow) begin
      void'(q.pop_front());
      mSeq = (mSeq + 1) % 256;
    end
    if (outFlag) begin
      if (q.size() < DEPTH) q.push_back(outVec);
      else mOvf = 1;
    end
    if (xfer) mIdx = popNow ? 0 : mIdx + 1;
    if (mValid) begin
      if (popNow) mValid = (q.size() != 0);
    end else begin
      mValid = (sizeBefore != 0);
    end
  endtask

  task automatic checkOutputs();
    chk("byteValid", byteValid, mValid);
    chk("byteData",  byteData,  expData());
    chk("fifoCount", fifoCount, q.size());
    chk("overflow",  overflow,  mOvf);
    chk("busy",      busy,      mValid || q.size() != 0);
  endtask

  // Called at the falling edge with inputs already set for the next rising edge.
  task automatic step();
    if (byteValid && byteReady) rxLog.push_back(byteData);
    modelEdge();
    @(posedge clock);
    @(negedge clock);
    checkOutputs();
  endtask

  task automatic doReset();
    reset   = 1'b0;
    outFlag = 1'b0;
    byteReady = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    checkOutputs();
  endtask

  task automatic drain(input int n, input int budget, input logic [3:0] pat, output int cycles);
    rxLog.delete();
    cycles  = 0;
    outFlag = 1'b0;
    while (rxLog.size() < n && cycles < budget) begin
      byteReady = pat[cycles % 4];
      step();
      cycles++;
    end
    chk("drain_beats", rxLog.size(), n);
  endtask

  task automatic pushVec(input logic [47:0] v);
    outVec  = v;
    outFlag = 1'b1;
    step();
    outFlag = 1'b0;
  endtask

  function automatic logic [47:0] mkVec(input int base);
    logic [47:0] v;
    for (int j = 0; j < VS; j++) v[j*8 +: 8] = 8'(base + j);
    return v;
  endfunction

  initial begin
    vecRec_t tbl[4];
    int      cyc;
    logic [47:0] v;

    tbl[0] = '{vec: 48'h060504030201, readyPat: 4'b1111, expStream: 48'h010203040506};
    tbl[1] = '{vec: 48'h060504030201, readyPat: 4'b1001, expStream: 48'h010203040506};
    tbl[2] = '{vec: 48'hFFEEDDCCBBAA, readyPat: 4'b0101, expStream: 48'hAABBCCDDEEFF};
    tbl[3] = '{vec: 48'h00FF80017F10, readyPat: 4'b0011, expStream: 48'h107F0180FF00};

    doReset();
    chk("reset_byteValid", byteValid, 1'b0);
    chk("reset_fifoCount", fifoCount, 3'd0);

`ifndef VEC_OUT_HEADER_EN
    // Single vectors with various ready patterns, incl. backpressure.
    for (int t = 0; t < 4; t++) begin
      byteReady = 1'b0;
      pushVec(tbl[t].vec);
      chk("latency_not_yet_valid", byteValid, 1'b0);
      drain(VS, 60, tbl[t].readyPat, cyc);
      for (int i = 0; i < VS && i < rxLog.size(); i++)
        chk($sformatf("vec%0d_beat%0d", t, i), rxLog[i], tbl[t].expStream[(VS-1-i)*8 +: 8]);
      if (t == 0) chk("no_stall_cycles", cyc, VS + 1);
      byteReady = 1'b1;
      step();
      step();
      chk("idle_busy", busy, 1'b0);
      chk("no_extra_beats", rxLog.size(), VS);
    end

    // Overflow with ready held low, then gapless drain of the stored four.
    doReset();
    for (int k = 0; k < 5; k++) pushVec(mkVec(16*k));
    chk("ovf_count", fifoCount, 3'd4);
    chk("ovf_flag", overflow, 1'b1);
    drain(24, 100, 4'b1111, cyc);
    chk("ovf_no_bubble", cyc, 24);
    for (int i = 0; i < 24 && i < rxLog.size(); i++)
      chk($sformatf("ovf_beat%0d", i), rxLog[i], 8'(16*(i/VS) + i%VS));
    step();
    step();
    chk("ovf_dropped_not_sent", rxLog.size(), 24);
    chk("ovf_sticky", overflow, 1'b1);

    // Full FIFO, push on the same edge as the last-lane pop.
    doReset();
    for (int k = 0; k < 4; k++) pushVec(mkVec(16*k + 3));
    drain(VS - 1, 50, 4'b1111, cyc);
    outVec    = mkVec(8'hA0);
    outFlag   = 1'b1;
    byteReady = 1'b1;
    step();
    outFlag = 1'b0;
    chk("fullpop_count", fifoCount, 3'd4);
    chk("fullpop_overflow", overflow, 1'b0);

    // Asynchronous reset in the middle of a vector.
    doReset();
    pushVec(48'h161514131211);
    drain(3, 30, 4'b1111, cyc);
    #2 reset = 1'b0;
    modelReset();
    #1;
    chk("async_byteValid", byteValid, 1'b0);
    chk("async_byteData", byteData, 8'h00);
    chk("async_fifoCount", fifoCount, 3'd0);
    chk("async_busy", busy, 1'b0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    byteReady = 1'b0;
    pushVec(48'h262524232221);
    drain(VS, 30, 4'b1111, cyc);
    if (rxLog.size() > 0) chk("after_reset_lane0", rxLog[0], 8'h21);
    step();
    chk("after_reset_beats", rxLog.size(), VS);
`else
    // Sequence-number header prefixes each vector.
    doReset();
    for (int k = 0; k < 3; k++) pushVec(mkVec(8'h40 + 16*k));
    drain(3*BEATS, 100, 4'b1111, cyc);
    if (rxLog.size() == 21) begin
      chk("hdr_seq0", rxLog[0], 8'h00);
      chk("hdr_seq1", rxLog[7], 8'h01);
      chk("hdr_seq2", rxLog[14], 8'h02);
      chk("hdr_v0_lane0", rxLog[1], 8'h40);
      chk("hdr_v1_lane0", rxLog[8], 8'h50);
      chk("hdr_v2_lane5", rxLog[20], 8'h65);
    end
    byteReady = 1'b1;
    step();
    step();
    chk("hdr_total_beats", rxLog.size(), 21);
`endif

    // Random traffic against the queue model.
    doReset();
    for (int c = 0; c < 800; c++) begin
      outFlag   = ($urandom_range(0, 99) < 30);
      outVec    = {16'($urandom), $urandom};
      byteReady = ($urandom_range(0, 99) < 65);
      step();
    end
    outFlag = 1'b0;
    drain(q.size() * BEATS - mIdx, 400, 4'b1111, cyc);
    step();
    chk("rand_final_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
